// File: rtl/fast_square_sweep_ctrl_pkg.sv
// Shared definitions for the fast-square sweep controller: FSM state encoding,
// config register bit layout and setting-register reset values.
package fast_square_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESTART,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RECORD,
        ST_STEP,
        ST_DONE
    } state_e;

    localparam int CFG_STEPS_LSB = 0;
    localparam int CFG_STEPS_MSB = 7;
    localparam int CFG_CONT_BIT  = 8;
    localparam int CFG_EN_BIT    = 9;

    localparam logic [7:0] DEF_NUM_STEPS = 8'd34;
    localparam int         DEF_TICKS     = 35000;
    localparam int         DEF_SETTLE    = 0;

    // A programmed step count of zero still runs one step.
    function automatic logic [7:0] last_step_idx(input logic [7:0] numSteps);
        return (numSteps == 8'd0) ? 8'd0 : numSteps - 8'd1;
    endfunction

endpackage

// File: rtl/fast_square_pulse_gen.sv
// Retriggerable fixed-width pulse generator: pulse_o is high for PULSE_CYCLES
// clocks starting the clock after trig_i; clr_i aborts a pulse in progress.
module fast_square_pulse_gen #(
    parameter int PULSE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic trig_i,
    input  logic clr_i,
    output logic pulse_o
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (trig_i) begin
            cnt_d = CW'(PULSE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Synthesizer frequency-sweep sequencer (restart, lock, settle, record, step).
// Define FAST_SQUARE_LOCK_TIMEOUT_EN to bound the lock wait by TIMEOUT_TICKS.
module fast_square_sweep_ctrl
    import fast_square_sweep_ctrl_pkg::*;
#(
    parameter logic [6:0] ADDR_CFG      = 7'd64,
    parameter logic [6:0] ADDR_TICKS    = 7'd65,
    parameter logic [6:0] ADDR_SETTLE   = 7'd66,
    parameter int         TICKS_W       = 20,
    parameter int         PULSE_CYCLES  = 4,
    parameter logic [TICKS_W-1:0] TIMEOUT_TICKS = 20'd640000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        pll_locked,
    output logic        freq_step_reset_out,
    output logic        freq_step_out,
    output logic        rx_reset,
    output logic        rx_next,
    output logic        rx_record,
    output logic [7:0]  step_idx,
    output logic        sweep_done,
    output logic        lock_fault
);

`ifdef FAST_SQUARE_LOCK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [TICKS_W-1:0] PULSE_LAST   = TICKS_W'(PULSE_CYCLES - 1);
    localparam logic [TICKS_W-1:0] TIMEOUT_LAST = TIMEOUT_TICKS - TICKS_W'(1);

    logic [7:0]         cfgSteps_q;
    logic               cfgCont_q;
    logic               cfgEn_q;
    logic [TICKS_W-1:0] cfgTicks_q;
    logic [TICKS_W-1:0] cfgSettle_q;
    logic               cfgWrite;

    logic [7:0]         shdLast_q;
    logic               shdCont_q;
    logic [TICKS_W-1:0] shdTicks_q;
    logic [TICKS_W-1:0] shdSettle_q;

    logic [1:0]         sync_q;
    logic               locked;

    state_e             state_q, state_d;
    logic [TICKS_W-1:0] cnt_q, cnt_d;
    logic [7:0]         stepIdx_q, stepIdx_d;
    logic               lockFault_q;

    logic               faultSet;
    logic               lossDiscard;
    logic               sweepDone;
    logic               zeroStep;
    logic [TICKS_W-1:0] recLast;
    logic [TICKS_W-1:0] settleLast;

    logic               unused_serial_hi;
    assign unused_serial_hi = ^serial_data[31:TICKS_W];

    assign cfgWrite = serial_strobe && (serial_addr == ADDR_CFG);

    always_ff @(posedge clock) begin
        if (reset) begin
            cfgSteps_q  <= DEF_NUM_STEPS;
            cfgCont_q   <= 1'b0;
            cfgEn_q     <= 1'b0;
            cfgTicks_q  <= TICKS_W'(DEF_TICKS);
            cfgSettle_q <= TICKS_W'(DEF_SETTLE);
        end else if (serial_strobe) begin
            if (serial_addr == ADDR_CFG) begin
                cfgSteps_q <= serial_data[CFG_STEPS_MSB:CFG_STEPS_LSB];
                cfgCont_q  <= serial_data[CFG_CONT_BIT];
                cfgEn_q    <= serial_data[CFG_EN_BIT];
            end
            if (serial_addr == ADDR_TICKS) begin
                cfgTicks_q <= serial_data[TICKS_W-1:0];
            end
            if (serial_addr == ADDR_SETTLE) begin
                cfgSettle_q <= serial_data[TICKS_W-1:0];
            end
        end
    end

    // Shadows freeze the sweep setup for the whole sweep; reloaded only in RESTART.
    always_ff @(posedge clock) begin
        if (reset) begin
            shdLast_q   <= last_step_idx(DEF_NUM_STEPS);
            shdCont_q   <= 1'b0;
            shdTicks_q  <= TICKS_W'(DEF_TICKS);
            shdSettle_q <= TICKS_W'(DEF_SETTLE);
        end else if (state_q == ST_RESTART) begin
            shdLast_q   <= last_step_idx(cfgSteps_q);
            shdCont_q   <= cfgCont_q;
            shdTicks_q  <= cfgTicks_q;
            shdSettle_q <= cfgSettle_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked     = sync_q[1];
    assign recLast    = (shdTicks_q == '0) ? '0 : shdTicks_q - TICKS_W'(1);
    assign settleLast = (shdSettle_q == '0) ? '0 : shdSettle_q - TICKS_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stepIdx_q   <= 8'd0;
            lockFault_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stepIdx_q <= stepIdx_d;
            if (faultSet) begin
                lockFault_q <= 1'b1;
            end else if (cfgWrite) begin
                lockFault_q <= 1'b0;
            end
        end
    end

    // The shared counter restarts on every state change; a timeout restart keeps step_idx.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + TICKS_W'(1);
        stepIdx_d   = stepIdx_q;
        faultSet    = 1'b0;
        lossDiscard = 1'b0;
        sweepDone   = 1'b0;
        zeroStep    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfgEn_q) begin
                    state_d  = ST_RESTART;
                    zeroStep = 1'b1;
                end
            end
            ST_RESTART: begin
                if (cnt_q >= PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked) begin
                    state_d = (shdSettle_q == '0) ? ST_RECORD : ST_SETTLE;
                end else if (TIMEOUT_EN && (cnt_q >= TIMEOUT_LAST)) begin
                    faultSet = 1'b1;
                    state_d  = ST_RESTART;
                end
            end
            ST_SETTLE: begin
                if (!locked) begin
                    faultSet    = 1'b1;
                    lossDiscard = 1'b1;
                    state_d     = ST_WAIT_LOCK;
                end else if (cnt_q >= settleLast) begin
                    state_d = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (!locked) begin
                    faultSet    = 1'b1;
                    lossDiscard = 1'b1;
                    state_d     = ST_WAIT_LOCK;
                end else if (cnt_q >= recLast) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (cnt_q >= PULSE_LAST) begin
                    stepIdx_d = (stepIdx_q == 8'hFF) ? stepIdx_q : stepIdx_q + 8'd1;
                    if (stepIdx_q == shdLast_q) begin
                        sweepDone = 1'b1;
                        if (shdCont_q) begin
                            state_d  = ST_RESTART;
                            zeroStep = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!cfgEn_q) begin
            state_d = ST_IDLE;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        if (zeroStep && (state_d == ST_RESTART)) begin
            stepIdx_d = 8'd0;
        end
    end

    fast_square_pulse_gen #(
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_reset_pulse (
        .clock   (clock),
        .reset   (reset),
        .trig_i  ((state_d == ST_RESTART) && (state_q != ST_RESTART)),
        .clr_i   (state_d == ST_IDLE),
        .pulse_o (freq_step_reset_out)
    );

    fast_square_pulse_gen #(
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_step_pulse (
        .clock   (clock),
        .reset   (reset),
        .trig_i  ((state_d == ST_STEP) && (state_q != ST_STEP)),
        .clr_i   (state_d == ST_IDLE),
        .pulse_o (freq_step_out)
    );

    assign rx_reset   = (state_q == ST_IDLE) || (state_q == ST_RESTART);
    assign rx_record  = (state_q == ST_RECORD) && locked;
    assign rx_next    = ((state_q == ST_STEP) && (cnt_q == '0)) || lossDiscard;
    assign step_idx   = stepIdx_q;
    assign sweep_done = sweepDone;
    assign lock_fault = lockFault_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed self-checking bench for fast_square_sweep_ctrl (default build).
module tb_fast_square_sweep_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  serial_addr = 7'd0;
    logic [31:0] serial_data = 32'd0;
    logic        serial_strobe = 1'b0;
    logic        pll_locked = 1'b0;
    logic        freq_step_reset_out;
    logic        freq_step_out;
    logic        rx_reset;
    logic        rx_next;
    logic        rx_record;
    logic [7:0]  step_idx;
    logic        sweep_done;
    logic        lock_fault;

    int compared   = 0;
    int mismatched = 0;

    int rstPulses, rstWmin, rstWmax, runRst;
    int recWin, recWmin, recWmax, runRec, recRises;
    int stepPulses, stepWmin, stepWmax, runStep;
    int doneCnt, nextCnt;
    logic pRst, pRec, pStep;
    logic [7:0] recIdx [0:15];

    fast_square_sweep_ctrl dut (
        .clock               (clock),
        .reset               (reset),
        .serial_addr         (serial_addr),
        .serial_data         (serial_data),
        .serial_strobe       (serial_strobe),
        .pll_locked          (pll_locked),
        .freq_step_reset_out (freq_step_reset_out),
        .freq_step_out       (freq_step_out),
        .rx_reset            (rx_reset),
        .rx_next             (rx_next),
        .rx_record           (rx_record),
        .step_idx            (step_idx),
        .sweep_done          (sweep_done),
        .lock_fault          (lock_fault)
    );

    always #5 clock = ~clock;

    task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
        @(negedge clock);
        serial_addr   = a;
        serial_data   = d;
        serial_strobe = 1'b1;
        @(negedge clock);
        serial_strobe = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic clearStats();
        rstPulses = 0; rstWmin = 9999; rstWmax = 0; runRst = 0;
        recWin = 0; recWmin = 9999; recWmax = 0; runRec = 0; recRises = 0;
        stepPulses = 0; stepWmin = 9999; stepWmax = 0; runStep = 0;
        doneCnt = 0; nextCnt = 0;
        pRst = 1'b0; pRec = 1'b0; pStep = 1'b0;
        for (int i = 0; i < 16; i++) recIdx[i] = 8'hEE;
    endtask

    // Collects pulse counts/widths on the falling clock edge for the tests to judge.
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (freq_step_reset_out) runRst++;
            else if (pRst) begin
                rstPulses++;
                if (runRst < rstWmin) rstWmin = runRst;
                if (runRst > rstWmax) rstWmax = runRst;
                runRst = 0;
            end
            pRst = freq_step_reset_out;
            if (rx_record && !pRec) begin
                if (recRises < 16) recIdx[recRises] = step_idx;
                recRises++;
            end
            if (rx_record) runRec++;
            else if (pRec) begin
                recWin++;
                if (runRec < recWmin) recWmin = runRec;
                if (runRec > recWmax) recWmax = runRec;
                runRec = 0;
            end
            pRec = rx_record;
            if (freq_step_out) runStep++;
            else if (pStep) begin
                stepPulses++;
                if (runStep < stepWmin) stepWmin = runStep;
                if (runStep > stepWmax) stepWmax = runStep;
                runStep = 0;
            end
            pStep = freq_step_out;
            if (sweep_done) doneCnt++;
            if (rx_next) nextCnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        @(posedge clock); #1;
        compared++;
        if ({rx_reset, rx_record, rx_next, freq_step_out, freq_step_reset_out, sweep_done, lock_fault} !== 7'b1000000) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got=%b want=1000000",
                     {rx_reset, rx_record, rx_next, freq_step_out, freq_step_reset_out, sweep_done, lock_fault});
        end
        compared++;
        if (step_idx !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_step_idx got=%0d want=0", step_idx);
        end
        @(negedge clock);
        reset = 1'b0;
        cycles(3);
        compared++;
        if (rx_reset !== 1'b1 || freq_step_reset_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset rx_reset=%b rst_pulse=%b want 1/0", rx_reset, freq_step_reset_out);
        end
    endtask

    task automatic test_single_sweep();
        pll_locked = 1'b1;
        cycles(3);
        write_reg(7'd65, 32'd10);
        write_reg(7'd66, 32'd0);
        clearStats();
        write_reg(7'd64, 32'h0000_0203);
        observe(100);
        compared++;
        if (rstPulses !== 1 || rstWmin !== 4 || rstWmax !== 4) begin
            mismatched++;
            $display("[TB] FAIL single_reset_pulse count=%0d wmin=%0d wmax=%0d want 1/4/4", rstPulses, rstWmin, rstWmax);
        end
        compared++;
        if (recWin !== 3 || recWmin !== 10 || recWmax !== 10) begin
            mismatched++;
            $display("[TB] FAIL single_record count=%0d wmin=%0d wmax=%0d want 3/10/10", recWin, recWmin, recWmax);
        end
        compared++;
        if (stepPulses !== 3 || stepWmin !== 4 || stepWmax !== 4) begin
            mismatched++;
            $display("[TB] FAIL single_step_pulse count=%0d wmin=%0d wmax=%0d want 3/4/4", stepPulses, stepWmin, stepWmax);
        end
        compared++;
        if (doneCnt !== 1 || nextCnt !== 3) begin
            mismatched++;
            $display("[TB] FAIL single_done_next done=%0d next=%0d want 1/3", doneCnt, nextCnt);
        end
        compared++;
        if (recIdx[0] !== 8'd0 || recIdx[1] !== 8'd1 || recIdx[2] !== 8'd2) begin
            mismatched++;
            $display("[TB] FAIL single_record_idx got=%0d,%0d,%0d want 0,1,2", recIdx[0], recIdx[1], recIdx[2]);
        end
        compared++;
        if (step_idx !== 8'd3 || rx_reset !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_done_state step_idx=%0d rx_reset=%b want 3/0", step_idx, rx_reset);
        end
        write_reg(7'd64, 32'h0000_0003);
        cycles(2);
        compared++;
        if (rx_reset !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL disable_to_idle rx_reset=%b want 1", rx_reset);
        end
    endtask

    task automatic test_zero_boundaries();
        write_reg(7'd65, 32'd0);
        clearStats();
        write_reg(7'd64, 32'h0000_0200);
        observe(40);
        compared++;
        if (recWin !== 1 || recWmax !== 1 || stepPulses !== 1 || doneCnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL zero_steps_ticks rec=%0d w=%0d steps=%0d done=%0d want 1/1/1/1", recWin, recWmax, stepPulses, doneCnt);
        end
        compared++;
        if (step_idx !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL zero_steps_idx got=%0d want 1", step_idx);
        end
        write_reg(7'd64, 32'h0000_0003);
        cycles(2);
    endtask

    task automatic test_continuous();
        write_reg(7'd65, 32'd10);
        clearStats();
        write_reg(7'd64, 32'h0000_0303);
        observe(200);
        compared++;
        if (doneCnt < 2) begin
            mismatched++;
            $display("[TB] FAIL cont_sweeps got=%0d want >=2", doneCnt);
        end
        compared++;
        if (rstPulses < 2 || rstWmin !== 4 || rstWmax !== 4) begin
            mismatched++;
            $display("[TB] FAIL cont_reset_pulses count=%0d wmin=%0d wmax=%0d want >=2/4/4", rstPulses, rstWmin, rstWmax);
        end
        compared++;
        if (recIdx[2] !== 8'd2 || recIdx[3] !== 8'd0 || recIdx[4] !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL cont_idx_wrap got=%0d,%0d,%0d want 2,0,1", recIdx[2], recIdx[3], recIdx[4]);
        end
        write_reg(7'd64, 32'h0000_0003);
        cycles(2);
    endtask

    task automatic test_no_timeout();
        pll_locked = 1'b0;
        cycles(4);
        clearStats();
        write_reg(7'd64, 32'h0000_0203);
        observe(300);
        compared++;
        if (rstPulses !== 1 || recWin !== 0 || lock_fault !== 1'b0 || rx_reset !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wait_lock_hold rst=%0d rec=%0d fault=%b rx_reset=%b want 1/0/0/0",
                     rstPulses, recWin, lock_fault, rx_reset);
        end
        write_reg(7'd64, 32'h0000_0003);
        cycles(2);
    endtask

    task automatic test_settle_and_loss();
        int k;
        bit hit;
        write_reg(7'd66, 32'd5);
        write_reg(7'd64, 32'h0000_0203);
        cycles(24);
        @(negedge clock);
        pll_locked = 1'b1;
        @(posedge clock);
        hit = 1'b0; k = 0;
        for (int i = 1; i <= 40 && !hit; i++) begin
            @(posedge clock); #1;
            if (rx_record) begin hit = 1'b1; k = i; end
        end
        compared++;
        if (!hit || k !== 7) begin
            mismatched++;
            $display("[TB] FAIL settle_latency got=%0d hit=%b want 7", k, hit);
        end
        for (int i = 0; i < 3; i++) @(posedge clock);
        @(negedge clock);
        pll_locked = 1'b0;
        hit = 1'b0; k = 0;
        for (int i = 1; i <= 10 && !hit; i++) begin
            @(posedge clock); #1;
            if (!rx_record) begin hit = 1'b1; k = i; end
        end
        compared++;
        if (!hit || k > 3 || rx_next !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL loss_drop clocks=%0d rx_next=%b want <=3/1", k, rx_next);
        end
        @(posedge clock); @(posedge clock); #1;
        compared++;
        if (lock_fault !== 1'b1 || step_idx !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL loss_fault fault=%b step_idx=%0d want 1/0", lock_fault, step_idx);
        end
        @(negedge clock);
        pll_locked = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clock); #1;
            if (rx_record) hit = 1'b1;
        end
        compared++;
        if (!hit || step_idx !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL relock_same_step hit=%b step_idx=%0d want 1/0", hit, step_idx);
        end
        k = 0;
        for (int i = 0; i < 40 && rx_record; i++) begin
            k++;
            @(posedge clock); #1;
        end
        compared++;
        if (k !== 10) begin
            mismatched++;
            $display("[TB] FAIL relock_record_width got=%0d want 10", k);
        end
    endtask

    task automatic test_enable_drop();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(posedge clock); #1;
            if (rx_record) hit = 1'b1;
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("[TB] FAIL enable_drop_wait got=no_record want record");
        end
        for (int i = 0; i < 3; i++) @(posedge clock);
        write_reg(7'd64, 32'h0000_0003);
        @(posedge clock); #1;
        compared++;
        if (rx_record !== 1'b0 || rx_reset !== 1'b1 || lock_fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL enable_drop rec=%b rx_reset=%b fault=%b want 0/1/0", rx_record, rx_reset, lock_fault);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        write_reg(7'd64, 32'h0000_0203);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clock); #1;
            if (rx_record && step_idx == 8'd1) hit = 1'b1;
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_wait got=no_step1_record want record");
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        compared++;
        if (rx_record !== 1'b0 || rx_reset !== 1'b1 || step_idx !== 8'd0 || freq_step_out !== 1'b0 || sweep_done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid rec=%b rx_reset=%b idx=%0d step=%b done=%b want 0/1/0/0/0",
                     rx_record, rx_reset, step_idx, freq_step_out, sweep_done);
        end
        @(negedge clock);
        reset = 1'b0;
        cycles(10);
        compared++;
        if (rx_reset !== 1'b1 || freq_step_reset_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_idle rx_reset=%b rst_pulse=%b want 1/0", rx_reset, freq_step_reset_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_zero_boundaries();
        test_continuous();
        test_no_timeout();
        test_settle_and_loss();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
